// File: rtl/gamepad_pkg.sv
// rtl/gamepad_pkg.sv - shared constants for the Gamepad Pmod receiver
// Frame length, button bit positions within a frame (first bit received
// lands in the MSB) and the default silence timeout.
package gamepad_pkg;

    localparam int NUM_BITS               = 12;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1048576;

    localparam int BTN_B      = 11;
    localparam int BTN_Y      = 10;
    localparam int BTN_SELECT = 9;
    localparam int BTN_START  = 8;
    localparam int BTN_UP     = 7;
    localparam int BTN_DOWN   = 6;
    localparam int BTN_LEFT   = 5;
    localparam int BTN_RIGHT  = 4;
    localparam int BTN_A      = 3;
    localparam int BTN_X      = 2;
    localparam int BTN_L      = 1;
    localparam int BTN_R      = 0;

    typedef logic [NUM_BITS-1:0] btn_vec_t;

endpackage

// File: rtl/sync_rise.sv
// rtl/sync_rise.sv - 2-FF synchronizer with a rising-edge detector
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input
//   level      : synchronized level (2nd flop)
//   rise       : high for one cycle when level goes 0 -> 1 (2nd vs 3rd flop)
module sync_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic level,
    output logic rise
);

    logic ff1_q, ff2_q, ff3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
            ff3_q <= 1'b0;
        end else begin
            ff1_q <= d;
            ff2_q <= ff1_q;
            ff3_q <= ff2_q;
        end
    end

    assign level = ff2_q;
    assign rise  = ff2_q & ~ff3_q;

endmodule

// File: rtl/gamepad_pmod_receiver.sv
// rtl/gamepad_pmod_receiver.sv - Gamepad Pmod serial frame receiver
// Ports:
//   clk, rst_n                   : system clock, asynchronous active-low reset
//   pmod_data/pmod_clk/pmod_latch: asynchronous serial interface from the Pmod
//   b .. r                       : registered button levels, 1 = pressed
//   is_present                   : controller connected and frames arriving
//   frame_valid                  : 1-cycle pulse, outputs updated from a frame
//   frame_error                  : 1-cycle pulse, latch with wrong bit count
module gamepad_pmod_receiver #(
    parameter int NUM_BITS       = gamepad_pkg::NUM_BITS,
    parameter int TIMEOUT_CYCLES = gamepad_pkg::DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pmod_data,
    input  logic pmod_clk,
    input  logic pmod_latch,
    output logic b,
    output logic y,
    output logic select,
    output logic start,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic a,
    output logic x,
    output logic l,
    output logic r,
    output logic is_present,
    output logic frame_valid,
    output logic frame_error
);

    import gamepad_pkg::*;

    localparam int BCW = $clog2(NUM_BITS + 2);
    localparam int WDW = $clog2(TIMEOUT_CYCLES);

    localparam logic [BCW-1:0] CNT_FULL = BCW'(NUM_BITS);
    localparam logic [BCW-1:0] CNT_SAT  = BCW'(NUM_BITS + 1);
    localparam logic [WDW-1:0] WD_MAX   = WDW'(TIMEOUT_CYCLES - 1);

    logic data_s;
    logic clk_rise;
    logic latch_rise;
    logic clk_level_unused;
    logic latch_level_unused;
    logic data_rise_unused;

    sync_rise u_sync_data (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pmod_data),
        .level (data_s),
        .rise  (data_rise_unused)
    );

    sync_rise u_sync_clk (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pmod_clk),
        .level (clk_level_unused),
        .rise  (clk_rise)
    );

    sync_rise u_sync_latch (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pmod_latch),
        .level (latch_level_unused),
        .rise  (latch_rise)
    );

    logic [NUM_BITS-1:0] shift_q, shift_d;
    logic [NUM_BITS-1:0] btn_q,   btn_d;
    logic [BCW-1:0]      cnt_q,   cnt_d;
    logic [WDW-1:0]      wd_q,    wd_d;
    logic                pres_q,  pres_d;
    logic                fv_q,    fv_d;
    logic                fe_q,    fe_d;

    always_comb begin
        shift_d = shift_q;
        btn_d   = btn_q;
        cnt_d   = cnt_q;
        pres_d  = pres_q;
        fv_d    = 1'b0;
        fe_d    = 1'b0;
        wd_d    = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

        // A latch rise wins over a coincident clk rise: that clk edge is dropped.
        if (latch_rise) begin
            cnt_d = '0;
            if (cnt_q == CNT_FULL) begin
                fv_d = 1'b1;
                wd_d = '0;
                // An all-ones frame is what the bridge sends with no pad attached.
                if (&shift_q) begin
                    pres_d = 1'b0;
                    btn_d  = '0;
                end else begin
                    pres_d = 1'b1;
                    btn_d  = shift_q;
                end
            end else begin
                fe_d = 1'b1;
            end
        end else if (clk_rise) begin
            shift_d = {shift_q[NUM_BITS-2:0], data_s};
            if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // Silence: clear on the edge the watchdog reaches its ceiling and keep
        // clearing while it sits there, until a frame is accepted.
        if (!fv_d && (wd_d == WD_MAX)) begin
            btn_d  = '0;
            pres_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            btn_q   <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            pres_q  <= 1'b0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
        end else begin
            shift_q <= shift_d;
            btn_q   <= btn_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            pres_q  <= pres_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
        end
    end

    assign b           = btn_q[BTN_B];
    assign y           = btn_q[BTN_Y];
    assign select      = btn_q[BTN_SELECT];
    assign start       = btn_q[BTN_START];
    assign up          = btn_q[BTN_UP];
    assign down        = btn_q[BTN_DOWN];
    assign left        = btn_q[BTN_LEFT];
    assign right       = btn_q[BTN_RIGHT];
    assign a           = btn_q[BTN_A];
    assign x           = btn_q[BTN_X];
    assign l           = btn_q[BTN_L];
    assign r           = btn_q[BTN_R];
    assign is_present  = pres_q;
    assign frame_valid = fv_q;
    assign frame_error = fe_q;

endmodule

// File: tb/tb_gamepad_pmod_receiver.sv
// tb/tb_gamepad_pmod_receiver.sv - directed self-checking bench for gamepad_pmod_receiver
module tb_gamepad_pmod_receiver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pmod_data = 1'b0;
    logic pmod_clk = 1'b0;
    logic pmod_latch = 1'b0;

    logic b_v, y_v, sel_v, start_v, up_v, down_v, left_v, right_v, a_v, x_v, l_v, r_v;
    logic pres_v, fv_v, fe_v;
    logic b_t, y_t, sel_t, start_t, up_t, down_t, left_t, right_t, a_t, x_t, l_t, r_t;
    logic pres_t, fv_t, fe_t;

    logic [11:0] btn_v, btn_t;
    assign btn_v = {b_v, y_v, sel_v, start_v, up_v, down_v, left_v, right_v, a_v, x_v, l_v, r_v};
    assign btn_t = {b_t, y_t, sel_t, start_t, up_t, down_t, left_t, right_t, a_t, x_t, l_t, r_t};

    gamepad_pmod_receiver dut (
        .clk(clk), .rst_n(rst_n),
        .pmod_data(pmod_data), .pmod_clk(pmod_clk), .pmod_latch(pmod_latch),
        .b(b_v), .y(y_v), .select(sel_v), .start(start_v),
        .up(up_v), .down(down_v), .left(left_v), .right(right_v),
        .a(a_v), .x(x_v), .l(l_v), .r(r_v),
        .is_present(pres_v), .frame_valid(fv_v), .frame_error(fe_v)
    );

    gamepad_pmod_receiver #(.TIMEOUT_CYCLES(64)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .pmod_data(pmod_data), .pmod_clk(pmod_clk), .pmod_latch(pmod_latch),
        .b(b_t), .y(y_t), .select(sel_t), .start(start_t),
        .up(up_t), .down(down_t), .left(left_t), .right(right_t),
        .a(a_t), .x(x_t), .l(l_t), .r(r_t),
        .is_present(pres_t), .frame_valid(fv_t), .frame_error(fe_t)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad = 0;

    int nfv, nfe, fv_at;
    logic [11:0] btn_s, btn_ts;
    logic pres_s, pres_ts;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        pmod_data = v;
        pmod_clk = 1'b0;
        tick(3);
        pmod_clk = 1'b1;
        tick(3);
    endtask

    task automatic send_frame(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(bits[i]);
        pmod_clk = 1'b0;
        tick(3);
    endtask

    // Raise the latch and watch 8 cycles: pulse counts, first frame_valid
    // cycle, and a snapshot of both instances' outputs after the 4th edge.
    task automatic do_latch();
        nfv = 0;
        nfe = 0;
        fv_at = -1;
        pmod_latch = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fv_v) begin
                nfv++;
                if (fv_at < 0) fv_at = i;
            end
            if (fe_v) nfe++;
            if (i == 4) begin
                btn_s = btn_v;
                pres_s = pres_v;
                btn_ts = btn_t;
                pres_ts = pres_t;
            end
        end
        pmod_latch = 1'b0;
        tick(3);
    endtask

    initial begin
        int acc, drop_up, drop_pres, idle_pulses;

        // Reset and idle
        tick(3);
        @(negedge clk);
        check_val("reset_btn", {20'd0, btn_v}, 32'h0);
        check_val("reset_flags", {29'd0, pres_v, fv_v, fe_v}, 32'h0);
        check_val("reset_btn_t", {20'd0, btn_t}, 32'h0);
        rst_n = 1'b1;
        tick(1);
        idle_pulses = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (fv_v || fe_v || fv_t || fe_t) idle_pulses++;
        end
        tick(1);
        check_val("idle_pulses", idle_pulses, 0);
        check_val("idle_btn", {19'd0, pres_v, btn_v}, 32'h0);

        // Start only
        send_frame(16'h0100, 12);
        do_latch();
        check_val("start_btn", {20'd0, btn_s}, 32'h100);
        check_val("start_pres", {31'd0, pres_s}, 32'h1);
        check_val("start_nfv", nfv, 1);
        check_val("start_fv_at", fv_at, 3);
        check_val("start_nfe", nfe, 0);
        check_val("start_btn_t", {19'd0, pres_ts, btn_ts}, 32'h1100);

        // All ones: no controller
        send_frame(16'h0FFF, 12);
        do_latch();
        check_val("none_btn", {20'd0, btn_s}, 32'h0);
        check_val("none_pres", {31'd0, pres_s}, 32'h0);
        check_val("none_nfv", nfv, 1);

        // Left, then short and long frames
        send_frame(16'h0020, 12);
        do_latch();
        check_val("left_btn", {19'd0, pres_s, btn_s}, 32'h1020);
        send_frame(16'h0555, 11);
        do_latch();
        check_val("short_nfe", nfe, 1);
        check_val("short_nfv", nfv, 0);
        check_val("short_btn", {19'd0, pres_s, btn_s}, 32'h1020);
        send_frame(16'h1AAA, 13);
        do_latch();
        check_val("long_nfe", nfe, 1);
        check_val("long_nfv", nfv, 0);
        check_val("long_btn", {19'd0, pres_s, btn_s}, 32'h1020);

        // Watchdog on the 64-cycle instance
        send_frame(16'h0080, 12);
        acc = -1;
        drop_up = -1;
        drop_pres = -1;
        pmod_latch = 1'b1;
        for (int i = 1; i <= 120; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (fv_t && acc < 0) acc = i;
            if (acc >= 0 && i > acc && !up_t && drop_up < 0) drop_up = i;
            if (acc >= 0 && i > acc && !pres_t && drop_pres < 0) drop_pres = i;
        end
        pmod_latch = 1'b0;
        tick(3);
        check_val("wd_acc_seen", {31'd0, acc > 0}, 32'h1);
        check_val("wd_up_drop", drop_up - acc, 63);
        check_val("wd_pres_drop", drop_pres - acc, 63);
        check_val("wd_main_up", {31'd0, up_v}, 32'h1);
        send_frame(16'h0080, 12);
        do_latch();
        check_val("wd_restore", {19'd0, pres_ts, btn_ts}, 32'h1080);

        // Coincident clk and latch rise after 12 bits
        send_frame(16'h00A5, 12);
        pmod_data = 1'b1;
        pmod_clk = 1'b1;
        do_latch();
        pmod_clk = 1'b0;
        tick(3);
        check_val("coin_nfv", nfv, 1);
        check_val("coin_nfe", nfe, 0);
        check_val("coin_btn", {20'd0, btn_s}, 32'h0A5);
        send_frame(16'h0801, 12);
        do_latch();
        check_val("after_coin_nfv", nfv, 1);
        check_val("after_coin_btn", {20'd0, btn_s}, 32'h801);

        // Reset mid-frame
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        pmod_clk = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check_val("midrst_btn", {19'd0, pres_v, btn_v}, 32'h0);
        rst_n = 1'b1;
        tick(2);
        for (int i = 0; i < 6; i++) send_bit(1'b0);
        pmod_clk = 1'b0;
        tick(3);
        do_latch();
        check_val("midrst_nfe", nfe, 1);
        check_val("midrst_nfv", nfv, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
